nrzi_frame_rx: RTL and testbench

Receive-side counterpart of the toggle (T flip-flop) line encoder. A transmitter built from `T_FF` toggles the line for every 1 bit and holds it for every 0 bit. This block recovers the bit stream by XOR-ing the current line level with the previous one. It hunts for a sync word, deserializes one data word LSB-first, checks an even-parity bit, and presents the word with a one-cycle valid pulse. It sits between the serial line input and the parallel consumer logic.

---
 rtl/nrzi_pkg.sv | 9 +
 rtl/nrzi_frame_rx_decoder.sv | 18 +
 rtl/nrzi_frame_rx.sv | 86 ++++++++
 tb/tb_nrzi_frame_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/nrzi_pkg.sv
// nrzi_pkg: shared FSM state encodings and default sync pattern for the NRZI frame receiver.
package nrzi_pkg;
   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2
   } state_t;
   localparam logic [7:0] DEFAULT_SYNC = 8'h7E;
endpackage

// File: rtl/nrzi_frame_rx_decoder.sv
// nrzi_bit_decoder: recovers bits from a toggle-encoded line (inverse of a T flip-flop encoder).
// Ports: clk, rst (async, active-high), line_in (line level), bit_en (sample strobe),
//        dbit_o (decoded bit for the current line level, combinational).
module nrzi_bit_decoder (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   input  logic bit_en,
   output logic dbit_o
);
   logic prev_line_q;
   // A line change since the last strobe means a 1 was sent.
   assign dbit_o = line_in ^ prev_line_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_line_q <= 1'b0;
      else if (bit_en) prev_line_q <= line_in;
   end
endmodule

// File: rtl/nrzi_frame_rx.sv
// nrzi_frame_rx: hunts for a sync word on an NRZI line, deserializes one LSB-first word and checks even parity.
// Ports: clk, rst (async, active-high), line_in, bit_en (bit strobe),
//        bit_out (last decoded bit), busy (in DATA/PARITY), data_out (last word),
//        data_valid (one-cycle frame-complete pulse), parity_err (qualify with data_valid).
module nrzi_frame_rx
   import nrzi_pkg::*;
#(
   parameter int          WIDTH     = 8,
   parameter logic [7:0]  SYNC_WORD = DEFAULT_SYNC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             line_in,
   input  logic             bit_en,
   output logic             bit_out,
   output logic             busy,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             parity_err
);
   localparam int CW = $clog2(WIDTH);
   state_t           state_q;
   logic [7:0]       hunt_sr_q;
   logic [WIDTH-1:0] data_sr_q;
   logic [CW-1:0]    bit_cnt_q;
   logic             bit_out_q;
   logic [WIDTH-1:0] data_out_q;
   logic             data_valid_q;
   logic             parity_err_q;
   logic             dbit;
   logic [7:0]       hunt_d;
   nrzi_bit_decoder u_dec (
      .clk     (clk),
      .rst     (rst),
      .line_in (line_in),
      .bit_en  (bit_en),
      .dbit_o  (dbit)
   );
   assign hunt_d     = {hunt_sr_q[6:0], dbit};
   assign bit_out    = bit_out_q;
   assign busy       = state_q != ST_HUNT;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign parity_err = parity_err_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_HUNT;
         hunt_sr_q    <= '0;
         data_sr_q    <= '0;
         bit_cnt_q    <= '0;
         bit_out_q    <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         if (bit_en) begin
            bit_out_q <= dbit;
            case (state_q)
               ST_HUNT: begin
                  hunt_sr_q <= hunt_d;
                  if (hunt_d == SYNC_WORD) begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               ST_DATA: begin
                  data_sr_q[bit_cnt_q] <= dbit;
                  // Counter parks at WIDTH-1 so it never wraps.
                  if (bit_cnt_q == CW'(WIDTH - 1)) state_q <= ST_PARITY;
                  else bit_cnt_q <= bit_cnt_q + 1'b1;
               end
               ST_PARITY: begin
                  data_out_q   <= data_sr_q;
                  parity_err_q <= (^data_sr_q) ^ dbit;
                  data_valid_q <= 1'b1;
                  // Clearing keeps the next sync from overlapping this frame's bits.
                  hunt_sr_q    <= '0;
                  state_q      <= ST_HUNT;
               end
               default: state_q <= ST_HUNT;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_nrzi_frame_rx.sv
// tb_nrzi_frame_rx: directed and randomized frames through a golden toggle encoder, checked against a queue model.
module tb_nrzi_frame_rx;
   localparam int W = 8;
   localparam logic [7:0] SYNC = 8'h7E;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         line_in = 1'b0;
   logic         bit_en = 1'b0;
   logic         bit_out, busy, data_valid, parity_err;
   logic [W-1:0] data_out;
   int n_pass = 0;
   int n_chk = 0;
   int n_valid = 0;
   int gap = 0;
   int v0;
   bit q[$];
   logic enc = 1'b0;
   logic exp_bit = 1'b0, exp_busy = 1'b0, exp_valid = 1'b0, exp_perr = 1'b0;
   logic [W-1:0] exp_data = '0;

   nrzi_frame_rx #(.WIDTH(W), .SYNC_WORD(SYNC)) dut (
      .clk        (clk),
      .rst        (rst),
      .line_in    (line_in),
      .bit_en     (bit_en),
      .bit_out    (bit_out),
      .busy       (busy),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_outs();
      chk("bit_out", 32'(bit_out), 32'(exp_bit));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("data_valid", 32'(data_valid), 32'(exp_valid));
      chk("data_out", 32'(data_out), 32'(exp_data));
      chk("parity_err", 32'(parity_err), 32'(exp_perr));
      if (data_valid === 1'b1) n_valid++;
   endtask

   // Earliest position where the last 8 bits (zeros before the start) equal the sync word.
   function automatic int find_sync();
      logic [7:0] w;
      for (int k = 0; k < q.size(); k++) begin
         w = '0;
         for (int j = 0; j < 8; j++) if (k - j >= 0) w[j] = q[k-j];
         if (w == SYNC) return k;
      end
      return -1;
   endfunction

   task automatic model_push(input logic b);
      int k;
      logic [W-1:0] d;
      q.push_back(b);
      exp_bit = b;
      exp_valid = 1'b0;
      k = find_sync();
      if (k >= 0 && q.size() == k + W + 2) begin
         for (int i = 0; i < W; i++) d[i] = q[k+1+i];
         exp_data = d;
         exp_perr = (^d) ^ q[k+W+1];
         exp_valid = 1'b1;
         exp_busy = 1'b0;
         q.delete();
      end else exp_busy = (k >= 0);
   endtask

   task automatic step(input logic en, input logic ln);
      bit_en = en;
      line_in = ln;
      @(posedge clk);
      #1;
      bit_en = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      for (int i = 0; i < gap; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)));
         exp_valid = 1'b0;
         check_outs();
      end
      enc = enc ^ b;
      step(1'b1, enc);
      model_push(b);
      check_outs();
   endtask

   task automatic send_msb8(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_lsb(input logic [W-1:0] v);
      for (int i = 0; i < W; i++) send_bit(v[i]);
   endtask

   task automatic send_frame(input logic [W-1:0] v, input logic par);
      send_msb8(SYNC);
      send_lsb(v);
      send_bit(par);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      line_in = 1'b1;
      bit_en = 1'b0;
      #2;
      chk("rst_bit_out", 32'(bit_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_data_valid", 32'(data_valid), 32'd0);
      chk("rst_parity_err", 32'(parity_err), 32'd0);
      q.delete();
      enc = 1'b0;
      line_in = 1'b0;
      exp_bit = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0; exp_perr = 1'b0; exp_data = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_outs();
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();
      gap = 0;
      v0 = n_valid;
      repeat (20) send_bit(1'b0);
      chk("idle_no_valid", 32'(n_valid - v0), 32'd0);
      chk("idle_bit_out", 32'(bit_out), 32'd0);
      v0 = n_valid;
      send_frame(8'hA5, 1'b0);
      chk("nom_count", 32'(n_valid - v0), 32'd1);
      chk("nom_data", 32'(data_out), 32'hA5);
      chk("nom_perr", 32'(parity_err), 32'd0);
      v0 = n_valid;
      send_frame(8'hA5, 1'b1);
      chk("perr_count", 32'(n_valid - v0), 32'd1);
      chk("perr_data", 32'(data_out), 32'hA5);
      chk("perr_flag", 32'(parity_err), 32'd1);
      do_reset();
      gap = 2;
      v0 = n_valid;
      send_frame(8'hA5, 1'b0);
      chk("sparse_count", 32'(n_valid - v0), 32'd1);
      chk("sparse_data", 32'(data_out), 32'hA5);
      chk("sparse_perr", 32'(parity_err), 32'd0);
      gap = 0;
      do_reset();
      v0 = n_valid;
      send_frame(8'h7E, 1'b0);
      send_lsb(8'h7E);
      send_bit(1'b0);
      chk("insync_count", 32'(n_valid - v0), 32'd1);
      chk("insync_data", 32'(data_out), 32'h7E);
      do_reset();
      send_msb8(SYNC);
      repeat (4) send_bit(1'b1);
      do_reset();
      v0 = n_valid;
      send_frame(8'h3C, 1'b0);
      chk("midrst_count", 32'(n_valid - v0), 32'd1);
      chk("midrst_data", 32'(data_out), 32'h3C);
      chk("midrst_perr", 32'(parity_err), 32'd0);
      repeat (60) begin
         int r;
         gap = $urandom_range(0, 2);
         r = $urandom_range(0, 9);
         if (r < 6) send_frame(W'($urandom), 1'($urandom_range(0, 1)));
         else if (r < 8) repeat ($urandom_range(1, 12)) send_bit(1'($urandom_range(0, 1)));
         else if (r == 8) do_reset();
         else begin
            send_msb8(SYNC);
            repeat ($urandom_range(1, W)) send_bit(1'($urandom_range(0, 1)));
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
